// File: rtl/mem_access_stage_if.sv
// Bundles the upstream ALU handshake, data memory bus and writeback/redirect outputs of the
// memory-access stage.
interface mem_access_stage_if #(
  parameter int WIDTH   = 32,
  parameter int REGSIZE = 32
);
  // Upstream (ALU stage)
  logic               valid_in;
  logic               ready_in;
  logic [5:0]         opcode;
  logic [REGSIZE-1:0] alu_result;
  logic               zero_flag;
  logic [REGSIZE-1:0] store_data;
  logic [4:0]         dest_reg;
  logic [WIDTH-1:0]   branch_target;

  // Data memory
  logic               mem_req;
  logic               mem_we;
  logic [WIDTH-1:0]   mem_addr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH-1:0]   mem_rdata;
  logic               mem_ack;

  // Writeback and PC redirect
  logic               wb_valid;
  logic               wb_reg_write;
  logic [4:0]         wb_reg;
  logic [REGSIZE-1:0] wb_data;
  logic               branch_taken;
  logic [WIDTH-1:0]   branch_pc;
  logic               mem_error;

  modport master (
    input  valid_in, opcode, alu_result, zero_flag, store_data, dest_reg, branch_target,
           mem_rdata, mem_ack,
    output ready_in, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_reg_write, wb_reg, wb_data, branch_taken, branch_pc, mem_error
  );

  modport slave (
    output valid_in, opcode, alu_result, zero_flag, store_data, dest_reg, branch_target,
           mem_rdata, mem_ack,
    input  ready_in, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_reg_write, wb_reg, wb_data, branch_taken, branch_pc, mem_error
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: completes R-type/BEQ/other ops in one DONE cycle and runs
// LW/SW through a bounded-wait memory handshake with alignment and timeout faults.
module mem_access_stage #(
  parameter int WIDTH   = 32,
  parameter int REGSIZE = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  mem_access_stage_if.master bus
);

  localparam logic [5:0] OpRType = 6'd0;
  localparam logic [5:0] OpLw    = 6'd4;
  localparam logic [5:0] OpSw    = 6'd5;
  localparam logic [5:0] OpBeq   = 6'd6;

  typedef enum logic [1:0] {StIdle, StMemWait, StDone} state_t;

  state_t             r_state;
  logic               r_is_lw;
  logic [4:0]         r_dest;
  logic [4:0]         r_wait_cnt;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [WIDTH-1:0]   r_mem_addr;
  logic [WIDTH-1:0]   r_mem_wdata;
  logic               r_wb_valid;
  logic               r_wb_reg_write;
  logic [4:0]         r_wb_reg;
  logic [REGSIZE-1:0] r_wb_data;
  logic               r_branch_taken;
  logic [WIDTH-1:0]   r_branch_pc;
  logic               r_mem_error;

  logic w_is_mem;
  logic w_misaligned;
  logic w_timeout;

  assign w_is_mem     = (bus.opcode == OpLw) || (bus.opcode == OpSw);
  assign w_misaligned = |bus.alu_result[1:0];
  assign w_timeout    = (r_wait_cnt == 5'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_is_lw        <= 1'b0;
      r_dest         <= '0;
      r_wait_cnt     <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_reg       <= '0;
      r_wb_data      <= '0;
      r_branch_taken <= 1'b0;
      r_branch_pc    <= '0;
      r_mem_error    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.valid_in) begin
            r_dest   <= bus.dest_reg;
            r_is_lw  <= (bus.opcode == OpLw);
            r_wb_reg <= bus.dest_reg;
            if (w_is_mem && !w_misaligned) begin
              r_state     <= StMemWait;
              r_wait_cnt  <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= (bus.opcode == OpSw);
              r_mem_addr  <= bus.alu_result;
              r_mem_wdata <= bus.store_data;
            end else begin
              r_state    <= StDone;
              r_wb_valid <= 1'b1;
              if (bus.opcode == OpRType) begin
                r_wb_data      <= bus.alu_result;
                r_wb_reg_write <= (bus.dest_reg != 5'd0);
              end else if (w_is_mem) begin
                r_mem_error <= 1'b1;
              end else if (bus.opcode == OpBeq) begin
                r_branch_taken <= bus.zero_flag;
                r_branch_pc    <= bus.branch_target;
              end
            end
          end
        end
        StMemWait: begin
          // Ack takes priority over a timeout reached in the same cycle.
          if (bus.mem_ack) begin
            r_state    <= StDone;
            r_mem_req  <= 1'b0;
            r_wb_valid <= 1'b1;
            if (r_is_lw) begin
              r_wb_data      <= bus.mem_rdata;
              r_wb_reg_write <= (r_dest != 5'd0);
            end
          end else if (w_timeout) begin
            r_state     <= StDone;
            r_mem_req   <= 1'b0;
            r_wb_valid  <= 1'b1;
            r_mem_error <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 5'd1;
          end
        end
        StDone: begin
          r_state        <= StIdle;
          r_wb_valid     <= 1'b0;
          r_wb_reg_write <= 1'b0;
          r_branch_taken <= 1'b0;
          r_mem_error    <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.ready_in     = (r_state == StIdle);
  assign bus.mem_req      = r_mem_req;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_reg_write = r_wb_reg_write;
  assign bus.wb_reg       = r_wb_reg;
  assign bus.wb_data      = r_wb_data;
  assign bus.branch_taken = r_branch_taken;
  assign bus.branch_pc    = r_branch_pc;
  assign bus.mem_error    = r_mem_error;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed instructions push expected writeback
// records; a negedge monitor pops and compares on every wb_valid.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_access_stage_if #(.WIDTH(32), .REGSIZE(32)) bus ();

  mem_access_stage #(.WIDTH(32), .REGSIZE(32), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        bt;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic chk_data, input logic [31:0] data, input logic [4:0] rd,
                      input logic rw, input logic bt, input logic [31:0] pc, input logic err);
    exp_t e;
    e.chk_data = chk_data;
    e.data     = data;
    e.rd       = rd;
    e.rw       = rw;
    e.bt       = bt;
    e.pc       = pc;
    e.err      = err;
    q.push_back(e);
  endtask

  // Waits (bounded) for ready_in, presents one instruction and returns #1 after acceptance.
  task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic zf,
                       input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] bt);
    int n = 0;
    @(negedge clk);
    while (!bus.ready_in && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("issue_ready_wait", 64'(bus.ready_in), 64'd1);
    bus.opcode        = op;
    bus.alu_result    = alu;
    bus.zero_flag     = zf;
    bus.store_data    = sd;
    bus.dest_reg      = rd;
    bus.branch_target = bt;
    bus.valid_in      = 1'b1;
    @(posedge clk);
    #1 bus.valid_in = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wb_valid) begin
        if (q.size() == 0) begin
          check("wb_unexpected", 64'(bus.wb_valid), 64'd0);
        end else begin
          e = q.pop_front();
          check("wb_reg_write", 64'(bus.wb_reg_write), 64'(e.rw));
          check("mem_error", 64'(bus.mem_error), 64'(e.err));
          check("branch_taken", 64'(bus.branch_taken), 64'(e.bt));
          if (e.chk_data) begin
            check("wb_data", 64'(bus.wb_data), 64'(e.data));
            check("wb_reg", 64'(bus.wb_reg), 64'(e.rd));
          end
          if (e.bt) check("branch_pc", 64'(bus.branch_pc), 64'(e.pc));
        end
      end else if (bus.mem_error || bus.branch_taken) begin
        check("pulse_without_wb_valid", 64'({bus.mem_error, bus.branch_taken}), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst               = 1'b1;
    bus.valid_in      = 1'b0;
    bus.opcode        = '0;
    bus.alu_result    = '0;
    bus.zero_flag     = 1'b0;
    bus.store_data    = '0;
    bus.dest_reg      = '0;
    bus.branch_target = '0;
    bus.mem_rdata     = '0;
    bus.mem_ack       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_wb_data", 64'(bus.wb_data), 64'd0);
    check("rst_wb_reg", 64'(bus.wb_reg), 64'd0);
    check("rst_branch_pc", 64'(bus.branch_pc), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_in", 64'(bus.ready_in), 64'd1);

    // R-type, rd=5
    push(1'b1, 32'h2A, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(6'd0, 32'h0000_002A, 1'b0, 32'h0, 5'd5, 32'h0);
    @(negedge clk);
    check("r_ready_low", 64'(bus.ready_in), 64'd0);
    @(negedge clk);
    check("r_ready_back", 64'(bus.ready_in), 64'd1);

    // LW 0x100, ack in the third wait cycle
    push(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(6'd4, 32'h0000_0100, 1'b0, 32'h0, 5'd7, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lw_mem_req", 64'(bus.mem_req), 64'd1);
      check("lw_mem_addr", 64'(bus.mem_addr), 64'h100);
      check("lw_mem_we", 64'(bus.mem_we), 64'd0);
      if (k == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
    end
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    check("lw_req_dropped", 64'(bus.mem_req), 64'd0);

    // SW 0x104 with no ack: timeout
    push(1'b0, 32'h0, 5'd3, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(6'd5, 32'h0000_0104, 1'b0, 32'h0000_1234, 5'd3, 32'h0);
    @(negedge clk);
    check("sw_mem_we", 64'(bus.mem_we), 64'd1);
    check("sw_mem_wdata", 64'(bus.mem_wdata), 64'h1234);
    check("sw_mem_addr", 64'(bus.mem_addr), 64'h104);
    n = 0;
    while (bus.mem_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("sw_req_cycles", 64'(n), 64'(TIMEOUT));
    check("sw_ready_low", 64'(bus.ready_in), 64'd0);
    @(negedge clk);
    check("sw_ready_back", 64'(bus.ready_in), 64'd1);

    // Misaligned LW 0x102
    push(1'b0, 32'h0, 5'd8, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(6'd4, 32'h0000_0102, 1'b0, 32'h0, 5'd8, 32'h0);
    @(negedge clk);
    check("mis_no_req", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    check("mis_no_req_after", 64'(bus.mem_req), 64'd0);

    // BEQ taken then not taken
    push(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h40, 1'b0);
    push(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(6'd6, 32'h0, 1'b1, 32'h0, 5'd0, 32'h40);
    issue(6'd6, 32'h0, 1'b0, 32'h0, 5'd0, 32'h80);

    // Other opcode, then R-type to r0
    push(1'b0, 32'h0, 5'd4, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(6'd2, 32'h11, 1'b0, 32'h0, 5'd4, 32'h0);
    push(1'b1, 32'h77, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(6'd0, 32'h77, 1'b0, 32'h0, 5'd0, 32'h0);

    // Reset while in MEM_WAIT, late ack must be ignored
    issue(6'd4, 32'h0000_0200, 1'b0, 32'h0, 5'd9, 32'h0);
    @(negedge clk);
    check("rstw_req_before", 64'(bus.mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_0BAD;
    check("rstw_req_dropped", 64'(bus.mem_req), 64'd0);
    check("rstw_ready", 64'(bus.ready_in), 64'd1);
    @(negedge clk);
    check("rstw_ack_ignored_req", 64'(bus.mem_req), 64'd0);
    check("rstw_no_wb", 64'(bus.wb_valid), 64'd0);
    bus.mem_ack = 1'b0;
    push(1'b1, 32'h55, 5'd10, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(6'd0, 32'h55, 1'b0, 32'h0, 5'd10, 32'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
